button_command_frontend: RTL and testbench

//  Upstream front end of the associative buffer. Synchronises and debounces four
//  raw push-buttons and snapshots the key/data switches. Turns each debounced press

---
 rtl/button_command_frontend_pkg.sv | 47 ++++
 rtl/button_command_frontend_if.sv | 33 +++
 rtl/button_command_frontend_debouncer.sv | 49 ++++
 rtl/button_command_frontend.sv | 127 ++++++++++++
 tb/tb_button_command_frontend.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/button_command_frontend_pkg.sv
// Shared definitions for the button command front end and the associative buffer:
// command encodings, FSM states, button indices and the press-priority helper.
package button_command_frontend_pkg;

    typedef enum logic [1:0] {
        CTRL_NONE = 2'd0,
        CTRL_LOAD = 2'd1,
        CTRL_INCR = 2'd2,
        CTRL_CLR  = 2'd3
    } ctrl_t;

    typedef enum logic {
        IDLE         = 1'b0,
        WAIT_RELEASE = 1'b1
    } state_t;

    localparam int NUM_BTNS  = 4;
    localparam int BTN_INCR  = 0;
    localparam int BTN_LOAD  = 1;
    localparam int BTN_CLR   = 2;
    localparam int BTN_READ  = 3;

    typedef struct packed {
        logic  fire;
        logic  is_read;
        ctrl_t ctrl;
    } cmd_sel_t;

    // Simultaneous rising edges resolve as read > clr > load > incr.
    function automatic cmd_sel_t select_cmd(input logic [NUM_BTNS-1:0] rise);
        cmd_sel_t sel;
        sel.fire    = |rise;
        sel.is_read = 1'b0;
        sel.ctrl    = CTRL_NONE;
        if (rise[BTN_READ]) begin
            sel.is_read = 1'b1;
        end else if (rise[BTN_CLR]) begin
            sel.ctrl = CTRL_CLR;
        end else if (rise[BTN_LOAD]) begin
            sel.ctrl = CTRL_LOAD;
        end else if (rise[BTN_INCR]) begin
            sel.ctrl = CTRL_INCR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/button_command_frontend_if.sv
// Command bus from the front end into the associative buffer.
// Handshake: cmd_valid is a one-cycle strobe with no ready; the buffer must accept
// ctrl/key/data_in or start_reading in the very cycle cmd_valid is high.
interface button_command_frontend_if
    import button_command_frontend_pkg::*;
#(
    parameter int KEY_WIDTH  = 4,
    parameter int DATA_WIDTH = 4
) ();

    ctrl_t                 ctrl;
    logic [KEY_WIDTH-1:0]  key;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  start_reading;
    logic                  cmd_valid;

    modport master (
        output ctrl,
        output key,
        output data_in,
        output start_reading,
        output cmd_valid
    );

    modport slave (
        input ctrl,
        input key,
        input data_in,
        input start_reading,
        input cmd_valid
    );

endinterface

// File: rtl/button_command_frontend_debouncer.sv
// Two-flop synchroniser plus stability counter for one raw push-button.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples.
module button_command_frontend_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic async_reset,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]           sync_q, sync_d;
    logic                 level_q, level_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 synced;

    assign synced = sync_q[1];
    assign level  = level_q;

    always_comb begin
        sync_d  = {sync_q[0], raw};
        level_d = level_q;
        cnt_d   = cnt_q;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/button_command_frontend.sv
// Debounces four buttons, snapshots the switches and turns each debounced press
// into exactly one single-cycle command on the buffer's command bus.
module button_command_frontend
    import button_command_frontend_pkg::*;
#(
    parameter int KEY_WIDTH       = 4,
    parameter int DATA_WIDTH      = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                  clk,
    input  logic                  async_reset,
    input  logic                  btn_load,
    input  logic                  btn_incr,
    input  logic                  btn_clr,
    input  logic                  btn_read,
    input  logic [KEY_WIDTH-1:0]  sw_key,
    input  logic [DATA_WIDTH-1:0] sw_data,
    button_command_frontend_if.master cmd,
    output state_t                dbg_state
);

    logic [NUM_BTNS-1:0] raw_btn;
    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] rise;
    cmd_sel_t            sel;

    assign raw_btn = {btn_read, btn_clr, btn_load, btn_incr};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_deb
        button_command_frontend_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_deb (
            .clk        (clk),
            .async_reset(async_reset),
            .raw        (raw_btn[i]),
            .level      (level[i])
        );
    end

    state_t                state_q, state_d;
    logic [NUM_BTNS-1:0]   prev_q, prev_d;
    logic [KEY_WIDTH-1:0]  key_meta_q, key_meta_d, key_sync_q, key_sync_d;
    logic [DATA_WIDTH-1:0] data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  start_reading_q, start_reading_d;
    logic                  cmd_valid_q, cmd_valid_d;

    // prev_q tracks the debounced levels every cycle, so a button still held when
    // the FSM returns to IDLE produces no rising edge and cannot fire again.
    assign rise = level & ~prev_q;
    assign sel  = select_cmd(rise);

    always_comb begin
        prev_d          = level;
        key_meta_d      = sw_key;
        key_sync_d      = key_meta_q;
        data_meta_d     = sw_data;
        data_sync_d     = data_meta_q;
        state_d         = state_q;
        ctrl_d          = CTRL_NONE;
        key_d           = key_q;
        data_d          = data_q;
        start_reading_d = 1'b0;
        cmd_valid_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel.fire) begin
                    cmd_valid_d = 1'b1;
                    state_d     = WAIT_RELEASE;
                    if (sel.is_read) begin
                        start_reading_d = 1'b1;
                    end else begin
                        ctrl_d = sel.ctrl;
                        key_d  = key_sync_q;
                        data_d = data_sync_q;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (level == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q         <= IDLE;
            prev_q          <= '0;
            key_meta_q      <= '0;
            key_sync_q      <= '0;
            data_meta_q     <= '0;
            data_sync_q     <= '0;
            ctrl_q          <= CTRL_NONE;
            key_q           <= '0;
            data_q          <= '0;
            start_reading_q <= 1'b0;
            cmd_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            prev_q          <= prev_d;
            key_meta_q      <= key_meta_d;
            key_sync_q      <= key_sync_d;
            data_meta_q     <= data_meta_d;
            data_sync_q     <= data_sync_d;
            ctrl_q          <= ctrl_d;
            key_q           <= key_d;
            data_q          <= data_d;
            start_reading_q <= start_reading_d;
            cmd_valid_q     <= cmd_valid_d;
        end
    end

    assign cmd.ctrl          = ctrl_q;
    assign cmd.key           = key_q;
    assign cmd.data_in       = data_q;
    assign cmd.start_reading = start_reading_q;
    assign cmd.cmd_valid     = cmd_valid_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_button_command_frontend.sv
// Directed bench for button_command_frontend with a 4-cycle debounce window:
// latency, single-pulse behaviour, priority, release gating and reset recovery.
module tb_button_command_frontend;
    import button_command_frontend_pkg::*;

    logic       clk = 1'b0;
    logic       async_reset;
    logic       btn_load, btn_incr, btn_clr, btn_read;
    logic [3:0] sw_key, sw_data;
    state_t     dbg_state;

    int passed = 0;
    int total  = 0;

    int         n, first;
    logic [1:0] c;
    logic       sr, v;
    logic [3:0] k, d;

    always #5 clk = ~clk;

    button_command_frontend_if #(.KEY_WIDTH(4), .DATA_WIDTH(4)) cmd_bus ();

    button_command_frontend #(
        .KEY_WIDTH      (4),
        .DATA_WIDTH     (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (3)
    ) dut (
        .clk        (clk),
        .async_reset(async_reset),
        .btn_load   (btn_load),
        .btn_incr   (btn_incr),
        .btn_clr    (btn_clr),
        .btn_read   (btn_read),
        .sw_key     (sw_key),
        .sw_data    (sw_data),
        .cmd        (cmd_bus),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycles(input int num);
        repeat (num) @(negedge clk);
    endtask

    // Counts every active output cycle in the window and records the first one.
    task automatic watch(input int num, output int cnt, output int first_cyc,
                         output logic [1:0] f_ctrl, output logic f_sr, output logic f_v,
                         output logic [3:0] f_key, output logic [3:0] f_data);
        cnt = 0; first_cyc = 0; f_ctrl = '0; f_sr = 1'b0; f_v = 1'b0; f_key = '0; f_data = '0;
        for (int i = 1; i <= num; i++) begin
            @(negedge clk);
            if (cmd_bus.cmd_valid || cmd_bus.start_reading || cmd_bus.ctrl != CTRL_NONE) begin
                cnt++;
                if (cnt == 1) begin
                    first_cyc = i;
                    f_ctrl    = cmd_bus.ctrl;
                    f_sr      = cmd_bus.start_reading;
                    f_v       = cmd_bus.cmd_valid;
                    f_key     = cmd_bus.key;
                    f_data    = cmd_bus.data_in;
                end
            end
        end
    endtask

    initial begin
        async_reset = 1'b1;
        btn_load = 1'b0; btn_incr = 1'b0; btn_clr = 1'b0; btn_read = 1'b0;
        sw_key = 4'h0; sw_data = 4'h0;
        cycles(3);
        check("rst_ctrl", 32'(cmd_bus.ctrl), 0);
        check("rst_key", 32'(cmd_bus.key), 0);
        check("rst_data", 32'(cmd_bus.data_in), 0);
        check("rst_sr", 32'(cmd_bus.start_reading), 0);
        check("rst_valid", 32'(cmd_bus.cmd_valid), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        async_reset = 1'b0;
        cycles(2);

        // LOAD with switch snapshot, latency 7
        sw_key = 4'hA; sw_data = 4'h5;
        cycles(4);
        btn_load = 1'b1;
        watch(20, n, first, c, sr, v, k, d);
        check("load_count", 32'(n), 1);
        check("load_latency", 32'(first), 7);
        check("load_ctrl", 32'(c), 32'(CTRL_LOAD));
        check("load_valid", 32'(v), 1);
        check("load_sr", 32'(sr), 0);
        check("load_key", 32'(k), 32'hA);
        check("load_data", 32'(d), 32'h5);
        sw_key = 4'h3; sw_data = 4'hC;
        cycles(4);
        check("load_key_held", 32'(cmd_bus.key), 32'hA);
        check("load_data_held", 32'(cmd_bus.data_in), 32'h5);
        check("load_state_wait", 32'(dbg_state), 32'(WAIT_RELEASE));
        btn_load = 1'b0;
        cycles(10);
        check("load_state_idle", 32'(dbg_state), 32'(IDLE));

        // Asynchronous reset between edges clears outputs immediately
        #2;
        async_reset = 1'b1;
        #1;
        check("arst_key", 32'(cmd_bus.key), 0);
        check("arst_data", 32'(cmd_bus.data_in), 0);
        check("arst_ctrl", 32'(cmd_bus.ctrl), 0);
        cycles(3);
        check("arst_key_held", 32'(cmd_bus.key), 0);
        check("arst_data_held", 32'(cmd_bus.data_in), 0);
        check("arst_valid_held", 32'(cmd_bus.cmd_valid), 0);
        async_reset = 1'b0;
        cycles(3);

        // Bouncing CLR: short pulses are filtered, one command after the final rise
        for (int i = 0; i < 4; i++) begin
            btn_clr = ~btn_clr;
            watch(2, n, first, c, sr, v, k, d);
            check("bounce_quiet", 32'(n), 0);
        end
        btn_clr = 1'b1;
        watch(20, n, first, c, sr, v, k, d);
        check("clr_count", 32'(n), 1);
        check("clr_latency", 32'(first), 7);
        check("clr_ctrl", 32'(c), 32'(CTRL_CLR));
        check("clr_key", 32'(k), 32'h3);
        check("clr_data", 32'(d), 32'hC);
        btn_clr = 1'b0;
        cycles(10);

        // READ beats INCR when both rise together
        btn_incr = 1'b1; btn_read = 1'b1;
        watch(20, n, first, c, sr, v, k, d);
        check("read_count", 32'(n), 1);
        check("read_latency", 32'(first), 7);
        check("read_sr", 32'(sr), 1);
        check("read_ctrl", 32'(c), 32'(CTRL_NONE));
        check("read_valid", 32'(v), 1);
        btn_incr = 1'b0; btn_read = 1'b0;
        cycles(10);
        sw_key = 4'h6; sw_data = 4'h9;
        cycles(4);
        btn_incr = 1'b1;
        watch(20, n, first, c, sr, v, k, d);
        check("incr_count", 32'(n), 1);
        check("incr_ctrl", 32'(c), 32'(CTRL_INCR));
        check("incr_key", 32'(k), 32'h6);
        check("incr_data", 32'(d), 32'h9);
        btn_incr = 1'b0;
        cycles(10);

        // Presses during WAIT_RELEASE are ignored
        btn_load = 1'b1;
        watch(12, n, first, c, sr, v, k, d);
        check("hold_load_count", 32'(n), 1);
        check("hold_load_ctrl", 32'(c), 32'(CTRL_LOAD));
        btn_clr = 1'b1;
        watch(15, n, first, c, sr, v, k, d);
        check("hold_clr_ignored", 32'(n), 0);
        btn_load = 1'b0;
        watch(15, n, first, c, sr, v, k, d);
        check("partial_release_quiet", 32'(n), 0);
        check("partial_release_wait", 32'(dbg_state), 32'(WAIT_RELEASE));
        btn_clr = 1'b0;
        watch(10, n, first, c, sr, v, k, d);
        check("release_quiet", 32'(n), 0);
        check("release_idle", 32'(dbg_state), 32'(IDLE));
        btn_clr = 1'b1;
        watch(20, n, first, c, sr, v, k, d);
        check("clr2_count", 32'(n), 1);
        check("clr2_latency", 32'(first), 7);
        check("clr2_ctrl", 32'(c), 32'(CTRL_CLR));
        btn_clr = 1'b0;
        cycles(10);

        // Reset during WAIT_RELEASE with LOAD held -> one fresh LOAD afterwards
        btn_load = 1'b1;
        watch(12, n, first, c, sr, v, k, d);
        check("pre_rst_count", 32'(n), 1);
        check("pre_rst_state", 32'(dbg_state), 32'(WAIT_RELEASE));
        async_reset = 1'b1;
        #1;
        check("mid_rst_key", 32'(cmd_bus.key), 0);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        cycles(2);
        async_reset = 1'b0;
        watch(30, n, first, c, sr, v, k, d);
        check("post_rst_count", 32'(n), 1);
        check("post_rst_latency", 32'(first), 7);
        check("post_rst_ctrl", 32'(c), 32'(CTRL_LOAD));
        watch(20, n, first, c, sr, v, k, d);
        check("post_rst_no_repeat", 32'(n), 0);
        btn_load = 1'b0;
        cycles(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
